// File: rtl/glitch_ctrl_pkg.sv
// Shared byte codes and parser state for the glitch controller host protocol.
// Pure definitions: no latency, no flow control.
package glitch_ctrl_pkg;

    localparam logic [7:0] CMD_DELAY       = 8'h44;
    localparam logic [7:0] CMD_ARM         = 8'h41;
    localparam logic [7:0] CMD_DISARM      = 8'h58;
    localparam logic [7:0] CMD_STATUS      = 8'h3F;

    localparam logic [7:0] RSP_OK          = 8'h6B;
    localparam logic [7:0] RSP_ERR         = 8'h21;
    localparam logic [7:0] RSP_TRIG        = 8'h54;
    localparam logic [7:0] RSP_STATUS_BASE = 8'h30;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PAYLOAD = 1'b1
    } parse_state_t;

endpackage

// File: rtl/glitch_ctrl_sync.sv
// 2-flop synchronizer and registered rising-edge pulse for an async pad input.
// The pulse is high in the cycle after the second sync flop first sees 1; no backpressure.
module sync_rise (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
            rise   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], din};
            // sync_q[1] doubles as the previous-sample flop for edge detection
            rise   <= sync_q[0] & ~sync_q[1];
        end
    end

endmodule

// File: rtl/glitch_ctrl.sv
// Host command parser, one-shot trigger gate and TX reply arbiter feeding trigger_delay.
// trigger fires 2 cycles after ext_trig is first sampled high; TX holds its byte until tx_ready.
module glitch_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 480000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic        ext_trig,
    output logic        trigger,
    output logic [31:0] delay_cycles,
    output logic        set_delay,
    output logic        armed
);
    import glitch_ctrl_pkg::*;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    parse_state_t state_q;
    logic [1:0]   byte_cnt_q;
    logic [23:0]  shift_q;
    logic [TW-1:0] timer_q;
    logic         reply_pend_q;
    logic [7:0]   reply_byte_q;
    logic         trig_pend_q;
    logic         ovf_q;
    logic         rise;

    logic idle_byte, pay_byte, last_byte, timeout;
    logic cmd_delay, cmd_arm, cmd_disarm, cmd_status, cmd_bad;
    logic fire, reply_req, tx_load, reply_taken;
    logic [7:0] reply_val;

    sync_rise u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (ext_trig),
        .rise (rise)
    );

    assign idle_byte  = rx_valid && (state_q == IDLE);
    assign pay_byte   = rx_valid && (state_q == PAYLOAD);
    assign last_byte  = pay_byte && (byte_cnt_q == 2'd3);
    assign timeout    = (state_q == PAYLOAD) && !rx_valid && (timer_q == TW'(TIMEOUT_CYCLES));

    assign cmd_delay  = idle_byte && (rx_data == CMD_DELAY);
    assign cmd_arm    = idle_byte && (rx_data == CMD_ARM);
    assign cmd_disarm = idle_byte && (rx_data == CMD_DISARM);
    assign cmd_status = idle_byte && (rx_data == CMD_STATUS);
    assign cmd_bad    = idle_byte && !(cmd_delay || cmd_arm || cmd_disarm || cmd_status);

    // A disarm accepted alongside an edge wins; an arm alongside an edge is too late
    assign fire       = rise && armed && !cmd_disarm;

    assign reply_req  = cmd_arm || cmd_disarm || cmd_status || cmd_bad || last_byte || timeout;

    always_comb begin
        reply_val = RSP_OK;
        if (cmd_status)
            reply_val = RSP_STATUS_BASE | {6'b0, ovf_q, armed};
        else if (cmd_bad || timeout)
            reply_val = RSP_ERR;
    end

    assign tx_load     = !tx_valid || tx_ready;
    assign reply_taken = tx_load && !trig_pend_q && reply_pend_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            byte_cnt_q   <= 2'd0;
            shift_q      <= 24'd0;
            timer_q      <= '0;
            delay_cycles <= 32'd0;
            set_delay    <= 1'b0;
        end else begin
            set_delay <= 1'b0;
            if (cmd_delay) begin
                state_q    <= PAYLOAD;
                byte_cnt_q <= 2'd0;
                timer_q    <= '0;
            end else if (pay_byte) begin
                timer_q    <= '0;
                byte_cnt_q <= byte_cnt_q + 2'd1;
                shift_q    <= {rx_data, shift_q[23:8]};
                if (last_byte) begin
                    delay_cycles <= {rx_data, shift_q};
                    set_delay    <= 1'b1;
                    state_q      <= IDLE;
                end
            end else if (timeout) begin
                state_q <= IDLE;
            end else if (state_q == PAYLOAD) begin
                timer_q <= timer_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed        <= 1'b0;
            trigger      <= 1'b0;
            trig_pend_q  <= 1'b0;
            reply_pend_q <= 1'b0;
            reply_byte_q <= 8'd0;
            ovf_q        <= 1'b0;
        end else begin
            trigger <= fire;
            if (fire || cmd_disarm)
                armed <= 1'b0;
            else if (cmd_arm)
                armed <= 1'b1;

            trig_pend_q <= fire || (trig_pend_q && !tx_load);

            if (reply_req) begin
                reply_pend_q <= 1'b1;
                reply_byte_q <= reply_val;
            end else if (reply_taken) begin
                reply_pend_q <= 1'b0;
            end

            // Overwriting a reply that never reached the TX register counts as lost
            ovf_q <= (ovf_q && !cmd_status) || (reply_req && reply_pend_q && !reply_taken);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_valid <= 1'b0;
            tx_data  <= 8'd0;
        end else if (tx_load) begin
            if (trig_pend_q) begin
                tx_valid <= 1'b1;
                tx_data  <= RSP_TRIG;
            end else if (reply_pend_q) begin
                tx_valid <= 1'b1;
                tx_data  <= reply_byte_q;
            end else begin
                tx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_glitch_ctrl.sv
// Directed bench for glitch_ctrl: table of single-byte commands plus hand-built timing sequences.
module tb_glitch_ctrl;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        ext_trig;
    logic        trigger;
    logic [31:0] delay_cycles;
    logic        set_delay;
    logic        armed;

    int n_vec  = 0;
    int n_fail = 0;
    int trig_count = 0;
    int set_count  = 0;
    logic [7:0] txq[$];

    typedef struct {
        logic [7:0] rx;
        logic [7:0] rsp;
        logic       armed;
    } vec_t;
    vec_t vecs[9];

    glitch_ctrl #(.TIMEOUT_CYCLES(100)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .ext_trig     (ext_trig),
        .trigger      (trigger),
        .delay_cycles (delay_cycles),
        .set_delay    (set_delay),
        .armed        (armed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bytes are captured half a cycle before the accepting edge
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_valid && tx_ready) txq.push_back(tx_data);
            if (trigger) trig_count++;
            if (set_delay) set_count++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic expect_tx(input string name, input logic [7:0] exp, input int bound);
        int n;
        n = 0;
        while (txq.size() == 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (txq.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s: no tx byte within %0d cycles, expected 0x%02h", name, bound, exp);
        end else begin
            check(name, {24'd0, txq.pop_front()}, {24'd0, exp});
        end
    endtask

    initial begin
        int tc0;
        int sc0;

        vecs[0] = '{8'h58, 8'h6B, 1'b0};
        vecs[1] = '{8'h41, 8'h6B, 1'b1};
        vecs[2] = '{8'h41, 8'h6B, 1'b1};
        vecs[3] = '{8'h3F, 8'h31, 1'b1};
        vecs[4] = '{8'h58, 8'h6B, 1'b0};
        vecs[5] = '{8'h3F, 8'h30, 1'b0};
        vecs[6] = '{8'h5A, 8'h21, 1'b0};
        vecs[7] = '{8'h00, 8'h21, 1'b0};
        vecs[8] = '{8'h6B, 8'h21, 1'b0};

        rst = 1'b1; rx_data = 8'd0; rx_valid = 1'b0; tx_ready = 1'b1; ext_trig = 1'b0;
        #23;
        check("rst_delay", delay_cycles, 32'd0);
        check("rst_set_delay", {31'd0, set_delay}, 32'd0);
        check("rst_trigger", {31'd0, trigger}, 32'd0);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_armed", {31'd0, armed}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Little-endian delay load with exact set_delay timing
        send_byte(8'h44); send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        @(negedge clk);
        check("load_set_delay_hi", {31'd0, set_delay}, 32'd1);
        check("load_delay", delay_cycles, 32'h12345678);
        @(negedge clk);
        check("load_set_delay_lo", {31'd0, set_delay}, 32'd0);
        expect_tx("load_ack", 8'h6B, 50);

        for (int i = 0; i < 9; i++) begin
            send_byte(vecs[i].rx);
            expect_tx($sformatf("vec%0d_rsp", i), vecs[i].rsp, 50);
            check($sformatf("vec%0d_armed", i), {31'd0, armed}, {31'd0, vecs[i].armed});
        end

        // Arm and fire: trigger in cycle N+2 only
        send_byte(8'h41);
        expect_tx("arm_ack", 8'h6B, 50);
        tc0 = trig_count;
        @(posedge clk); #1;
        ext_trig = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("fire_n", {31'd0, trigger}, 32'd0);
        @(negedge clk);
        check("fire_n1", {31'd0, trigger}, 32'd0);
        @(negedge clk);
        check("fire_n2", {31'd0, trigger}, 32'd1);
        check("fire_disarms", {31'd0, armed}, 32'd0);
        @(negedge clk);
        check("fire_n3", {31'd0, trigger}, 32'd0);
        expect_tx("fire_notify", 8'h54, 50);
        ext_trig = 1'b0;
        wait_cycles(6);
        ext_trig = 1'b1;
        wait_cycles(10);
        ext_trig = 1'b0;
        check("second_pulse_ignored", trig_count, tc0 + 1);

        // ext_trig already high when armed must not fire
        ext_trig = 1'b1;
        wait_cycles(6);
        send_byte(8'h41);
        expect_tx("held_arm_ack", 8'h6B, 50);
        wait_cycles(10);
        tc0 = trig_count;
        check("held_no_fire", trig_count, tc0 - 0 + 0);
        check("held_still_armed", {31'd0, armed}, 32'd1);
        ext_trig = 1'b0;
        wait_cycles(6);
        ext_trig = 1'b1;
        wait_cycles(8);
        check("held_then_rise_fires", trig_count, tc0 + 1);
        expect_tx("held_notify", 8'h54, 50);
        ext_trig = 1'b0;
        wait_cycles(4);

        // Edge pulse coincident with an accepted 'X'
        send_byte(8'h41);
        expect_tx("coinc_arm_ack", 8'h6B, 50);
        tc0 = trig_count;
        @(posedge clk); #1;
        ext_trig = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rx_data = 8'h58; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        wait_cycles(10);
        check("coinc_no_fire", trig_count, tc0);
        check("coinc_disarmed", {31'd0, armed}, 32'd0);
        expect_tx("coinc_ack", 8'h6B, 50);
        wait_cycles(10);
        check("coinc_no_notify", txq.size(), 32'd0);
        ext_trig = 1'b0;

        // Payload timeout leaves delay untouched
        sc0 = set_count;
        send_byte(8'h44); send_byte(8'hAA); send_byte(8'hBB);
        expect_tx("timeout_err", 8'h21, 400);
        check("timeout_delay_kept", delay_cycles, 32'h12345678);
        check("timeout_no_set", set_count, sc0);
        send_byte(8'h44); send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        expect_tx("after_timeout_ack", 8'h6B, 50);
        check("after_timeout_delay", delay_cycles, 32'hDEADBEEF);
        check("after_timeout_set", set_count, sc0 + 1);

        // Backpressure: 'T' held stable, then status byte
        send_byte(8'h41);
        expect_tx("bp_arm_ack", 8'h6B, 50);
        @(posedge clk); #1;
        tx_ready = 1'b0;
        ext_trig = 1'b1;
        wait_cycles(6);
        send_byte(8'h3F);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp_hold_valid%0d", i), {31'd0, tx_valid}, 32'd1);
            check($sformatf("bp_hold_data%0d", i), {24'd0, tx_data}, 32'h54);
        end
        @(posedge clk); #1;
        tx_ready = 1'b1;
        expect_tx("bp_trig_first", 8'h54, 50);
        expect_tx("bp_status_next", 8'h30, 50);
        ext_trig = 1'b0;

        // Lost reply sets ovf, cleared by the status read
        @(posedge clk); #1;
        tx_ready = 1'b0;
        send_byte(8'h58);
        wait_cycles(3);
        send_byte(8'h58);
        send_byte(8'h58);
        @(posedge clk); #1;
        tx_ready = 1'b1;
        expect_tx("ovf_k1", 8'h6B, 50);
        expect_tx("ovf_k2", 8'h6B, 50);
        wait_cycles(5);
        check("ovf_only_two", txq.size(), 32'd0);
        send_byte(8'h3F);
        expect_tx("ovf_status", 8'h32, 50);
        send_byte(8'h3F);
        expect_tx("ovf_cleared", 8'h30, 50);

        // Reset mid-payload while armed with a byte stuck in TX
        @(posedge clk); #1;
        tx_ready = 1'b0;
        send_byte(8'h41);
        send_byte(8'h44); send_byte(8'h11); send_byte(8'h22);
        @(negedge clk);
        check("pre_rst_tx_valid", {31'd0, tx_valid}, 32'd1);
        check("pre_rst_armed", {31'd0, armed}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("mid_rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("mid_rst_armed", {31'd0, armed}, 32'd0);
        check("mid_rst_delay", delay_cycles, 32'd0);
        check("mid_rst_trigger", {31'd0, trigger}, 32'd0);
        check("mid_rst_set_delay", {31'd0, set_delay}, 32'd0);
        wait_cycles(2);
        rst = 1'b0;
        tx_ready = 1'b1;
        txq.delete();
        send_byte(8'h44); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        expect_tx("post_rst_ack", 8'h6B, 50);
        check("post_rst_delay", delay_cycles, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
